// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue slice: opcodes, ALU op encodings,
// and instruction field positions.
package alu_issue_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic logic is_alu_class(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LI);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_LI;
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// 4x8 register file: two async read ports, one sync write port, r0 reads zero.
module issue_regfile
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_raddr1,
  input  logic [1:0] i_raddr2,
  output logic [7:0] o_rdata1,
  output logic [7:0] o_rdata2,
  input  logic       i_we,
  input  logic [1:0] i_waddr,
  input  logic [7:0] i_wdata
);

  logic [7:0] r_reg1, r_reg2, r_reg3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg1 <= '0;
      r_reg2 <= '0;
      r_reg3 <= '0;
    end else if (i_we) begin
      case (i_waddr)
        2'd1:    r_reg1 <= i_wdata;
        2'd2:    r_reg2 <= i_wdata;
        2'd3:    r_reg3 <= i_wdata;
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] rd_mux(input logic [1:0] a, input logic [7:0] v1,
                                        input logic [7:0] v2, input logic [7:0] v3);
    case (a)
      2'd1:    return v1;
      2'd2:    return v2;
      2'd3:    return v3;
      default: return 8'h00;
    endcase
  endfunction

  assign o_rdata1 = rd_mux(i_raddr1, r_reg1, r_reg2, r_reg3);
  assign o_rdata2 = rd_mux(i_raddr2, r_reg1, r_reg2, r_reg3);

endmodule

// File: rtl/alu_issue.sv
// Single-entry ALU issue stage: decode, operand forwarding, valid/ready
// handshake and the EX register that drives an external combinational ALU.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        flush,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [1:0]  ex_rd,
  output logic        zero_flag,
  output logic        illegal
);

  logic [7:0] r_alu_a, r_alu_b;
  alu_op_e    r_alu_op;
  logic       r_ex_valid, r_zero_flag, r_illegal;
  logic [1:0] r_ex_rd;

  logic [3:0] w_opc;
  logic [1:0] w_rd, w_rs1, w_rs2;
  logic [7:0] w_imm, w_rf1, w_rf2, w_src1, w_src2, w_a, w_b;
  logic       w_accept, w_retire, w_wb;
  alu_op_e    w_op;

  assign w_opc = in_instr[OPC_MSB:OPC_LSB];
  assign w_rd  = in_instr[RD_MSB:RD_LSB];
  assign w_rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign w_rs2 = in_instr[RS2_MSB:RS2_LSB];
  assign w_imm = in_instr[IMM_MSB:IMM_LSB];

  assign in_ready = !flush && (!r_ex_valid || ex_ready);
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_ex_valid && ex_ready && !flush;
  assign w_wb     = w_retire && (r_ex_rd != 2'd0);

  issue_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rf1),
    .o_rdata2 (w_rf2),
    .i_we     (w_wb),
    .i_waddr  (r_ex_rd),
    .i_wdata  (alu_result)
  );

  // Retiring result bypasses the regfile so a dependent op can issue back-to-back.
  assign w_src1 = (w_wb && (w_rs1 == r_ex_rd)) ? alu_result : w_rf1;
  assign w_src2 = (w_wb && (w_rs2 == r_ex_rd)) ? alu_result : w_rf2;

  assign w_a = (w_opc == OP_LI) ? 8'h00 : w_src1;
  assign w_b = ((w_opc == OP_ADDI) || (w_opc == OP_LI)) ? w_imm : w_src2;

  always_comb begin
    w_op = ALU_ADD;
    case (w_opc)
      OP_SUB:  w_op = ALU_SUB;
      OP_AND:  w_op = ALU_AND;
      OP_OR:   w_op = ALU_OR;
      default: w_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= ALU_ADD;
      r_ex_rd     <= '0;
      r_zero_flag <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_accept && is_illegal_op(w_opc);
      if (w_retire)
        r_zero_flag <= alu_zero;
      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept && is_alu_class(w_opc)) begin
        r_ex_valid <= 1'b1;
        r_alu_a    <= w_a;
        r_alu_b    <= w_b;
        r_alu_op   <= w_op;
        r_ex_rd    <= w_rd;
      end else if (w_retire) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign ex_valid  = r_ex_valid;
  assign ex_rd     = r_ex_rd;
  assign zero_flag = r_zero_flag;
  assign illegal   = r_illegal;

endmodule
